// File: rtl/edge_frame_ctrl_if.sv
// Camera-side stimulus and display-side results of the edge frame sequencer.
// The sequencer takes the slave view; whatever drives the camera stream takes the master view.
interface edge_frame_ctrl_if;
    logic        edge_req;
    logic        frame_start;
    logic        pix_valid;
    logic [7:0]  in_R;
    logic [7:0]  in_G;
    logic [7:0]  in_B;
    logic [7:0]  edge_R_in;
    logic        edge_ready;
    logic        err_clr;

    logic [7:0]  pix_R;
    logic [7:0]  pix_G;
    logic [7:0]  pix_B;
    logic [12:0] row;
    logic [12:0] col;
    logic        edge_en;
    logic [7:0]  out_R;
    logic [7:0]  out_G;
    logic [7:0]  out_B;
    logic        out_valid;
    logic [1:0]  mode;
    logic [19:0] frame_cycles;
    logic        err_short;
    logic        err_long;

    modport master (
        output edge_req, frame_start, pix_valid, in_R, in_G, in_B,
               edge_R_in, edge_ready, err_clr,
        input  pix_R, pix_G, pix_B, row, col, edge_en, out_R, out_G, out_B,
               out_valid, mode, frame_cycles, err_short, err_long
    );

    modport slave (
        input  edge_req, frame_start, pix_valid, in_R, in_G, in_B,
               edge_R_in, edge_ready, err_clr,
        output pix_R, pix_G, pix_B, row, col, edge_en, out_R, out_G, out_B,
               out_valid, mode, frame_cycles, err_short, err_long
    );
endinterface

// File: rtl/edge_frame_ctrl.sv
// Frame sequencer for edge_detect: pixel->pix/row/col 1 cycle, pixel->out 2 cycles, mode on frame boundaries.
// No backpressure: one pixel per cycle max; pixels beyond a full frame are dropped and flagged.
module edge_frame_ctrl #(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    edge_frame_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [12:0] LAST_COL = 13'(IMG_WIDTH - 1);
    localparam logic [12:0] LAST_ROW = 13'(IMG_HEIGHT - 1);
    localparam logic [1:0]  WARM_CNT = 2'(WARMUP_FRAMES);
    localparam logic [19:0] CYC_MAX  = 20'hFFFFF;

    state_t      state_q, state_d;
    logic [1:0]  prime_cnt_q, prime_cnt_d;
    logic        edge_en_q, edge_en_d;

    logic [12:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [12:0] col_base, row_base;
    logic        frame_full_q, frame_full_d, full_base;
    logic        any_pix_q, any_pix_d, any_base;
    logic        accept;

    logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
    logic [12:0] row_q, row_d, col_q, col_d;
    logic        pix_vld_q, pix_vld_d;

    logic [7:0]  out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
    logic [7:0]  edge_pix;
    logic        out_vld_q, out_vld_d;

    logic [19:0] cyc_q, cyc_d, frame_cycles_q, frame_cycles_d;
    logic        fc_armed_q, fc_armed_d;
    logic        err_short_q, err_short_d, err_long_q, err_long_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prime_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    // frame_full_q still describes the frame that is ending when frame_start arrives
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        if (bus.frame_start) begin
            case (state_q)
                IDLE: begin
                    if (bus.edge_req) begin
                        state_d     = PRIME;
                        prime_cnt_d = 2'd0;
                    end
                end
                PRIME: begin
                    if (!bus.edge_req) begin
                        state_d = IDLE;
                    end else if (frame_full_q) begin
                        prime_cnt_d = prime_cnt_q + 2'd1;
                        if (prime_cnt_d == WARM_CNT) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!bus.edge_req) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        edge_en_d = (state_d != IDLE);
        out_vld_d = pix_vld_q;
        out_r_d   = out_r_q;
        out_g_d   = out_g_q;
        out_b_d   = out_b_q;
        edge_pix  = bus.edge_ready ? bus.edge_R_in : 8'h00;
        if (pix_vld_q) begin
            if (state_q == RUN) begin
                out_r_d = edge_pix;
                out_g_d = edge_pix;
                out_b_d = edge_pix;
            end else begin
                out_r_d = pix_r_q;
                out_g_d = pix_g_q;
                out_b_d = pix_b_q;
            end
        end
    end

    // A coincident frame_start clears position state before the pixel is placed
    always_comb begin
        col_base  = bus.frame_start ? 13'd0 : col_cnt_q;
        row_base  = bus.frame_start ? 13'd0 : row_cnt_q;
        full_base = bus.frame_start ? 1'b0  : frame_full_q;
        any_base  = bus.frame_start ? 1'b0  : any_pix_q;
        accept    = bus.pix_valid & ~full_base;

        col_cnt_d    = col_base;
        row_cnt_d    = row_base;
        frame_full_d = full_base;
        any_pix_d    = any_base;
        pix_r_d      = pix_r_q;
        pix_g_d      = pix_g_q;
        pix_b_d      = pix_b_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_vld_d    = accept;

        if (accept) begin
            pix_r_d   = bus.in_R;
            pix_g_d   = bus.in_G;
            pix_b_d   = bus.in_B;
            row_d     = row_base;
            col_d     = col_base;
            any_pix_d = 1'b1;
            if (col_base == LAST_COL) begin
                col_cnt_d = 13'd0;
                row_cnt_d = row_base + 13'd1;
                if (row_base == LAST_ROW) begin
                    frame_full_d = 1'b1;
                end
            end else begin
                col_cnt_d = col_base + 13'd1;
            end
        end

        err_short_d = (err_short_q & ~bus.err_clr)
                    | (bus.frame_start & ~frame_full_q & any_pix_q);
        err_long_d  = (err_long_q & ~bus.err_clr) | (bus.pix_valid & full_base);

        // cyc_q counts the cycles since the last frame_start, including that one
        cyc_d          = bus.frame_start ? 20'd1 : ((cyc_q == CYC_MAX) ? cyc_q : cyc_q + 20'd1);
        frame_cycles_d = (bus.frame_start && fc_armed_q) ? cyc_q : frame_cycles_q;
        fc_armed_d     = fc_armed_q | bus.frame_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_en_q      <= 1'b0;
            col_cnt_q      <= 13'd0;
            row_cnt_q      <= 13'd0;
            frame_full_q   <= 1'b1;
            any_pix_q      <= 1'b0;
            pix_r_q        <= 8'd0;
            pix_g_q        <= 8'd0;
            pix_b_q        <= 8'd0;
            row_q          <= 13'd0;
            col_q          <= 13'd0;
            pix_vld_q      <= 1'b0;
            out_r_q        <= 8'd0;
            out_g_q        <= 8'd0;
            out_b_q        <= 8'd0;
            out_vld_q      <= 1'b0;
            cyc_q          <= 20'd0;
            frame_cycles_q <= 20'd0;
            fc_armed_q     <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
        end else begin
            edge_en_q      <= edge_en_d;
            col_cnt_q      <= col_cnt_d;
            row_cnt_q      <= row_cnt_d;
            frame_full_q   <= frame_full_d;
            any_pix_q      <= any_pix_d;
            pix_r_q        <= pix_r_d;
            pix_g_q        <= pix_g_d;
            pix_b_q        <= pix_b_d;
            row_q          <= row_d;
            col_q          <= col_d;
            pix_vld_q      <= pix_vld_d;
            out_r_q        <= out_r_d;
            out_g_q        <= out_g_d;
            out_b_q        <= out_b_d;
            out_vld_q      <= out_vld_d;
            cyc_q          <= cyc_d;
            frame_cycles_q <= frame_cycles_d;
            fc_armed_q     <= fc_armed_d;
            err_short_q    <= err_short_d;
            err_long_q     <= err_long_d;
        end
    end

    assign bus.pix_R        = pix_r_q;
    assign bus.pix_G        = pix_g_q;
    assign bus.pix_B        = pix_b_q;
    assign bus.row          = row_q;
    assign bus.col          = col_q;
    assign bus.edge_en      = edge_en_q;
    assign bus.out_R        = out_r_q;
    assign bus.out_G        = out_g_q;
    assign bus.out_B        = out_b_q;
    assign bus.out_valid    = out_vld_q;
    assign bus.mode         = state_q;
    assign bus.frame_cycles = frame_cycles_q;
    assign bus.err_short    = err_short_q;
    assign bus.err_long     = err_long_q;

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Randomized scoreboard bench for edge_frame_ctrl on a 4x2 frame with two warm-up frames.
module tb_edge_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int WH   = W * H;
    localparam int WARM = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    edge_frame_ctrl_if bus ();

    edge_frame_ctrl #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .WARMUP_FRAMES(WARM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] row;
        logic [12:0] col;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Frame-level reference state
    bit m_started;
    int m_n;
    int m_mode;
    int m_pcnt;
    bit m_es;
    bit m_el;
    int m_fc;
    bit m_seen_fs;
    int ncyc;
    int last_fs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: row/col sampled one cycle before out_valid belong to the same pixel
    logic [12:0] prev_row, prev_col;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_R", bus.out_R, mon_e.r);
                chk("out_G", bus.out_G, mon_e.g);
                chk("out_B", bus.out_B, mon_e.b);
                chk("row", prev_row, mon_e.row);
                chk("col", prev_col, mon_e.col);
            end
        end
        prev_row = bus.row;
        prev_col = bus.col;
    end

    task automatic cycle(input bit fs, input bit pv, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input bit clr);
        exp_t       e;
        bit         complete;
        logic [7:0] v;
        @(negedge clk);
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.in_R        = r;
        bus.in_G        = g;
        bus.in_B        = b;
        bus.err_clr     = clr;
        ncyc++;
        if (clr) begin
            m_es = 1'b0;
            m_el = 1'b0;
        end
        if (fs) begin
            if (m_started && m_n > 0 && m_n < WH) m_es = 1'b1;
            complete = !m_started || (m_n == WH);
            case (m_mode)
                0: if (bus.edge_req) begin m_mode = 1; m_pcnt = 0; end
                1: begin
                    if (!bus.edge_req) m_mode = 0;
                    else if (complete) begin
                        m_pcnt++;
                        if (m_pcnt == WARM) m_mode = 2;
                    end
                end
                default: if (!bus.edge_req) m_mode = 0;
            endcase
            if (m_seen_fs) m_fc = ncyc - last_fs;
            last_fs   = ncyc;
            m_seen_fs = 1'b1;
            m_started = 1'b1;
            m_n       = 0;
        end
        if (pv) begin
            if (m_started && m_n < WH) begin
                e.row = 13'(m_n / W);
                e.col = 13'(m_n % W);
                if (m_mode == 2) begin
                    v   = bus.edge_ready ? bus.edge_R_in : 8'h00;
                    e.r = v;
                    e.g = v;
                    e.b = v;
                end else begin
                    e.r = r;
                    e.g = g;
                    e.b = b;
                end
                sbq.push_back(e);
                m_n++;
            end else begin
                m_el = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("mode", bus.mode, m_mode);
        chk("edge_en", bus.edge_en, (m_mode != 0));
        chk("err_short", bus.err_short, m_es);
        chk("err_long", bus.err_long, m_el);
        chk("frame_cycles", bus.frame_cycles, m_fc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    // rbase < 0 selects random red values
    task automatic run_frame(input bit req, input int npix, input bit coin, input int rbase,
                             input bit gaps, input bit er, input logic [7:0] ev);
        logic [7:0] r;
        int         first;
        idle(2);
        bus.edge_req   = req;
        bus.edge_ready = er;
        bus.edge_R_in  = ev;
        first = 0;
        r = (rbase >= 0) ? 8'(rbase) : 8'($urandom);
        if (coin && npix > 0) begin
            cycle(1'b1, 1'b1, r, 8'($urandom), 8'($urandom), 1'b0);
            first = 1;
        end else begin
            cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        end
        for (int i = first; i < npix; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) idle(1);
            r = (rbase >= 0) ? 8'(rbase + i) : 8'($urandom);
            cycle(1'b0, 1'b1, r, 8'($urandom), 8'($urandom), 1'b0);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pix_R", bus.pix_R, 0);
        chk("rst_pix_G", bus.pix_G, 0);
        chk("rst_pix_B", bus.pix_B, 0);
        chk("rst_row", bus.row, 0);
        chk("rst_col", bus.col, 0);
        chk("rst_out_R", bus.out_R, 0);
        chk("rst_out_G", bus.out_G, 0);
        chk("rst_out_B", bus.out_B, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_edge_en", bus.edge_en, 0);
        chk("rst_err_short", bus.err_short, 0);
        chk("rst_err_long", bus.err_long, 0);
        chk("rst_mode", bus.mode, 0);
        chk("rst_frame_cycles", bus.frame_cycles, 0);
        m_started = 1'b0;
        m_n       = 0;
        m_mode    = 0;
        m_pcnt    = 0;
        m_es      = 1'b0;
        m_el      = 1'b0;
        m_fc      = 0;
        m_seen_fs = 1'b0;
        sbq.delete();
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.err_clr     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.edge_req    = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.in_R        = 8'h00;
        bus.in_G        = 8'h00;
        bus.in_B        = 8'h00;
        bus.edge_R_in   = 8'h00;
        bus.edge_ready  = 1'b0;
        bus.err_clr     = 1'b0;
        ncyc            = 0;
        last_fs         = 0;
        do_reset();

        // Bypass with a known red ramp
        run_frame(1'b0, 8, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00);

        // Warm-up: PRIME after 1st start, RUN after 3rd
        run_frame(1'b1, 8, 1'b0, -1, 1'b0, 1'b1, 8'hAB);
        chk("warm_mode_prime", bus.mode, 1);
        run_frame(1'b1, 8, 1'b0, -1, 1'b1, 1'b1, 8'hAB);
        chk("warm_mode_prime2", bus.mode, 1);
        run_frame(1'b1, 8, 1'b0, -1, 1'b0, 1'b1, 8'hAB);
        chk("warm_mode_run", bus.mode, 2);
        run_frame(1'b1, 8, 1'b0, -1, 1'b0, 1'b0, 8'hAB);

        // Short frame during PRIME delays RUN by one frame
        run_frame(1'b0, 8, 1'b0, -1, 1'b0, 1'b0, 8'h00);
        run_frame(1'b1, 5, 1'b0, -1, 1'b0, 1'b0, 8'h00);
        run_frame(1'b1, 8, 1'b0, -1, 1'b0, 1'b0, 8'h00);
        chk("short_err_set", bus.err_short, 1);
        chk("short_mode_prime", bus.mode, 1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("short_err_clr", bus.err_short, 0);
        run_frame(1'b1, 8, 1'b0, -1, 1'b0, 1'b1, 8'h5C);
        chk("short_mode_still_prime", bus.mode, 1);
        run_frame(1'b1, 8, 1'b0, -1, 1'b0, 1'b1, 8'h5C);
        chk("short_mode_run", bus.mode, 2);

        // Long frame: pixels 9 and 10 dropped
        run_frame(1'b1, 10, 1'b0, -1, 1'b0, 1'b1, 8'h33);
        idle(3);
        chk("long_row_hold", bus.row, 1);
        chk("long_col_hold", bus.col, 3);
        chk("long_err", bus.err_long, 1);

        // Drop edge_req mid-frame in RUN, then coincident start+pixel
        run_frame(1'b1, 3, 1'b0, -1, 1'b0, 1'b1, 8'h77);
        bus.edge_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        chk("drop_mode_hold", bus.mode, 2);
        run_frame(1'b0, 8, 1'b1, -1, 1'b0, 1'b0, 8'h00);
        chk("drop_mode_idle", bus.mode, 0);
        chk("drop_edge_en", bus.edge_en, 0);

        // 100-cycle frame period
        idle(2);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        idle(91);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("frame_cycles_100", bus.frame_cycles, 100);

        // Reset mid-frame with pixels in flight
        cycle(1'b0, 1'b1, 8'h99, 8'h98, 8'h97, 1'b0);
        cycle(1'b0, 1'b1, 8'h96, 8'h95, 8'h94, 1'b0);
        do_reset();

        // Random frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
            run_frame($urandom_range(0, 4) != 0, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                      -1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        idle(4);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/edge_frame_ctrl.md
# edge_frame_ctrl

Frame-level sequencer for the `edge_detect` datapath on the DE1-SoC D8M camera path. It turns the raw camera pixel stream into the `row`/`col`/`edge_en` stimulus that `edge_detect` expects. It runs the line-buffer warm-up frames before trusting the datapath's results, and muxes either the camera pixel (bypass) or the edge result onto the VGA-bound output. Mode changes requested by the user switch take effect only on frame boundaries, so the display never shows a torn frame.

## Interface
- `IMG_WIDTH`, 640, pixels per line
- `IMG_HEIGHT`, 480, lines per frame
- `WARMUP_FRAMES`, 2, complete frames fed to the datapath before its output is displayed (range 1..3)

- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `edge_req`  in  1  user request for edge mode (level); sampled only on `frame_start`
- `frame_start`  in  1  one-cycle pulse marking the start of a frame
- `pix_valid`  in  1  `in_R/G/B` carry a pixel this cycle
- `in_R`, `in_G`, `in_B`  in  8 each  camera pixel
- `edge_R_in`  in  8  `edge_R_out` from `edge_detect`
- `edge_ready`  in  1  `vga_reset` from `edge_detect` (datapath results valid)
- `err_clr`  in  1  clears sticky error flags
- `pix_R`, `pix_G`, `pix_B`  out  8 each  registered pixel to `edge_detect`
- `row`, `col`  out  13 each  coordinates of `pix_*`
- `edge_en`  out  1  enable to `edge_detect`
- `out_R`, `out_G`, `out_B`  out  8 each  display pixel
- `out_valid`  out  1  `out_*` carry a pixel
- `mode`  out  2  FSM state: 0 IDLE, 1 PRIME, 2 RUN
- `frame_cycles`  out  20  clk count of the last complete frame period (saturates at 2^20-1)
- `err_short`, `err_long`  out  1 each  sticky framing errors

## Operation
- Position counters `col_cnt` and `row_cnt`:
  - cleared on `frame_start`.
  - each accepted pixel registers `pix_* <= in_*`, `row <= row_cnt`, `col <= col_cnt`, then advances `col_cnt`.
  - `col_cnt` wraps from `IMG_WIDTH-1` to 0 and increments `row_cnt`.
  - on the last pixel (`IMG_HEIGHT-1`, `IMG_WIDTH-1`) the `frame_full` flag is set.
- Pixels arriving while `frame_full` is set are ignored: no `row`/`col` update and no output. They set `err_long`.
- `frame_start` arriving while `frame_full` is clear and at least one pixel has been accepted sets `err_short`. A `frame_start` with zero pixels accepted is not an error.
- `frame_start` and `pix_valid` in the same cycle: the counters clear first, and the pixel is taken as (0,0) of the new frame.
- FSM, evaluated only on `frame_start`:
  - IDLE -> PRIME when `edge_req`=1; `prime_cnt` is cleared.
  - PRIME:
    - `edge_req`=0 -> IDLE.
    - else, if the ending frame was complete (`frame_full`), `prime_cnt++`.
    - when `prime_cnt` reaches `WARMUP_FRAMES` -> RUN.
    - a short frame leaves `prime_cnt` unchanged.
  - RUN -> IDLE when `edge_req`=0.
  - A short frame in RUN stays in RUN.
- `edge_en` = 1 in PRIME and RUN, 0 in IDLE. It is registered and changes in the cycle after `frame_start`.
- Output mux:
  - IDLE/PRIME: `out_* <= pix_*` (bypass).
  - RUN: `out_R = out_G = out_B <= edge_R_in` when `edge_ready`=1, else 0x00.
- `out_valid` follows the accepted-pixel strobe, delayed to align with `out_*`.
- `frame_cycles`: a free-running counter is latched and cleared on each `frame_start`; the first latch after reset is discarded, so the output stays 0.
- `err_clr` clears both error flags. If `err_clr` and a new error occur in the same cycle, the error wins.

## Timing
- Reset values:
  - `pix_*`, `row`, `col`, `out_*`, `frame_cycles`: 0.
  - `out_valid`, `edge_en`, `err_*`: 0.
  - `mode`: IDLE.
- `rst` mid-frame aborts immediately. The next pixel is ignored until a `frame_start` is seen; `frame_full` is treated as set after reset.
- Input pixel -> `pix_*`/`row`/`col`: 1 cycle.
- Input pixel -> `out_*`/`out_valid`: 2 cycles.
- `frame_start` -> `mode`/`edge_en` update: 1 cycle.
- One pixel accepted per cycle maximum, with no backpressure.

## Test plan
Unless noted, `IMG_WIDTH`=4, `IMG_HEIGHT`=2, `WARMUP_FRAMES`=2.

- **Reset and bypass:** reset, `frame_start`, then 8 valid pixels with R=0x10..0x17 and `edge_req`=0. Required:
  - `row`/`col` sequence (0,0)(0,1)(0,2)(0,3)(1,0)...(1,3), one cycle after each pixel.
  - `out_R`=0x10..0x17 two cycles after each pixel.
  - `edge_en`=0 throughout.
- **Warm-up to RUN:** hold `edge_req`=1 across 4 full frames. Required:
  - `mode` goes 1 after the 1st `frame_start` and 2 after the 3rd.
  - In RUN with `edge_ready`=1 and `edge_R_in`=0xAB: `out_R`=`out_G`=`out_B`=0xAB.
  - With `edge_ready`=0: outputs 0x00.
- **Short frame during PRIME:** send 5 pixels, then `frame_start`. Required:
  - `err_short`=1.
  - `prime_cnt` unchanged, so RUN arrives one frame later than in the warm-up scenario.
  - `err_clr` returns `err_short` to 0.
- **Long frame:** send 10 pixels in a frame. Required:
  - pixels 9-10 produce no `out_valid`.
  - `row`/`col` hold at (1,3).
  - `err_long`=1.
- **Mode drop and coincident start:** drop `edge_req` mid-frame in RUN. Required: `mode` stays 2 until the next `frame_start`, then goes 0 and `edge_en`=0. Then assert `frame_start` and `pix_valid` in the same cycle; required: that pixel appears with `row`=0, `col`=0.
- **Frame period and reset abort:** use a 100-cycle frame period. Required: `frame_cycles`=100 after the second `frame_start`. Then assert `rst` mid-frame; required: all outputs return to their reset values asynchronously.
